flit_rr_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares the single 48-bit flit input of the depacketizer among NUM_SRC flit sources. Flit format: [47:32] header, [31:16] payload, [15:0] sideband. A header equal to TAIL_MARK marks the last flit of a packet. Once a source wins, it keeps the grant until its tail flit transfers, so packets never interleave. A one-entry registered output stage feeds the depacketizer, and a stall watchdog releases a hung grant.

---
 rtl/flit_rr_arbiter.sv | 169 ++++++++++++++++
 tb/tb_flit_rr_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_rr_arbiter.sv
// flit_rr_arbiter
// Packet-granular round-robin arbiter feeding one 48-bit flit stream to the
// depacketizer. A source that wins keeps the grant until its tail flit
// (header == TAIL_MARK) transfers, so packets never interleave. A one-entry
// output register decouples the sources from downstream, and a watchdog
// releases a grant whose owner stops presenting flits for TIMEOUT cycles.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   src_flit        packed source flits, source i at [48*i+47:48*i]
//   src_valid       per-source flit present
//   src_ready       per-source accept (valid & ready = transfer)
//   out_flit        registered flit to the depacketizer
//   out_valid       out_flit holds a valid flit
//   out_ready       downstream accepts out_flit
//   grant_id        locked source, or last granted source when idle
//   busy            high while a packet holds the grant
//   timeout_err     sticky, set when the watchdog forces a release
//   pkt_count       number of tail flits accepted (wrapping)
//
// FSM states:
//   state  | meaning
//   IDLE   | no packet in progress, arbitrate round-robin from rr_ptr
//   LOCKED | grant_id owns the output until its tail flit or a timeout
module flit_rr_arbiter #(
    parameter int          NUM_SRC   = 4,
    parameter logic [15:0] TAIL_MARK = 16'hFFFF,
    parameter int          TIMEOUT   = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_SRC*48-1:0]        src_flit,
    input  logic [NUM_SRC-1:0]           src_valid,
    output logic [NUM_SRC-1:0]           src_ready,
    output logic [47:0]                  out_flit,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(NUM_SRC)-1:0]   grant_id,
    output logic                         busy,
    output logic                         timeout_err,
    output logic [15:0]                  pkt_count
);

    localparam int GW = $clog2(NUM_SRC);
    localparam int IW = GW + 1;
    localparam int SW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [GW-1:0] LAST_SRC   = GW'(NUM_SRC - 1);
    localparam logic [GW-1:0] ONE_SRC    = GW'(1);
    localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t         state;
    logic [GW-1:0]  rr_ptr;
    logic [SW-1:0]  stall_cnt;

    logic           load_en;
    logic [GW-1:0]  pick;
    logic           found;
    logic [IW-1:0]  scan_idx;
    logic [GW-1:0]  sel;
    logic [47:0]    sel_flit;
    logic           ready_bit;
    logic           accept;
    logic           is_tail;

    function automatic logic [GW-1:0] next_src(input logic [GW-1:0] g);
        return (g == LAST_SRC) ? '0 : g + ONE_SRC;
    endfunction

    assign load_en = !out_valid || out_ready;

    // First valid source at or after rr_ptr, wrapping modulo NUM_SRC
    // (NUM_SRC need not be a power of two, so the wrap is explicit).
    always_comb begin
        pick     = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            scan_idx = {1'b0, rr_ptr} + IW'(k);
            if (scan_idx >= IW'(NUM_SRC))
                scan_idx = scan_idx - IW'(NUM_SRC);
            if (!found && src_valid[scan_idx[GW-1:0]]) begin
                pick  = scan_idx[GW-1:0];
                found = 1'b1;
            end
        end
    end

    // While locked, the owner sees ready whenever the output can load,
    // whether or not it is presenting a flit.
    assign sel       = (state == LOCKED) ? grant_id : pick;
    assign ready_bit = (state == LOCKED) ? load_en : (load_en && found);

    always_comb begin
        sel_flit  = '0;
        src_ready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == GW'(i)) begin
                sel_flit     = src_flit[48*i +: 48];
                src_ready[i] = ready_bit;
            end
        end
    end

    assign accept  = |(src_ready & src_valid);
    assign is_tail = (sel_flit[47:32] == TAIL_MARK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            stall_cnt   <= '0;
            out_flit    <= '0;
            out_valid   <= 1'b0;
            grant_id    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            pkt_count   <= '0;
        end else begin
            if (accept) begin
                out_flit  <= sel_flit;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        grant_id  <= pick;
                        stall_cnt <= '0;
                        if (is_tail) begin
                            rr_ptr    <= next_src(pick);
                            pkt_count <= pkt_count + 16'd1;
                        end else begin
                            state <= LOCKED;
                            busy  <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (accept) begin
                        stall_cnt <= '0;
                        if (is_tail) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            rr_ptr    <= next_src(grant_id);
                            pkt_count <= pkt_count + 16'd1;
                        end
                    end else if (load_en) begin
                        // Starved cycle: owner could send but did not.
                        if (stall_cnt == STALL_LAST) begin
                            state       <= IDLE;
                            busy        <= 1'b0;
                            timeout_err <= 1'b1;
                            rr_ptr      <= next_src(grant_id);
                            stall_cnt   <= '0;
                        end else begin
                            stall_cnt <= stall_cnt + SW'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flit_rr_arbiter.sv
module tb_flit_rr_arbiter;

    localparam int NUM_SRC = 4;
    localparam int TIMEOUT = 4;

    logic                    clk;
    logic                    reset;
    logic [NUM_SRC*48-1:0]   src_flit;
    logic [NUM_SRC-1:0]      src_valid;
    logic [NUM_SRC-1:0]      src_ready;
    logic [47:0]             out_flit;
    logic                    out_valid;
    logic                    out_ready;
    logic [1:0]              grant_id;
    logic                    busy;
    logic                    timeout_err;
    logic [15:0]             pkt_count;

    flit_rr_arbiter #(
        .NUM_SRC  (NUM_SRC),
        .TAIL_MARK(16'hFFFF),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .src_flit   (src_flit),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .out_flit   (out_flit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .grant_id   (grant_id),
        .busy       (busy),
        .timeout_err(timeout_err),
        .pkt_count  (pkt_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors    = 0;
    int miscompares = 0;

    // Per-source pending flits and the scoreboard of flits expected at the output.
    logic [47:0] sq [NUM_SRC][$];
    logic [47:0] expq [$];

    // Reference model: packet-level arbitration view.
    int m_owner;   // -1 when no packet in progress
    int m_rr;      // first source to consider at the next arbitration
    int m_starve;  // starved cycles of the current owner
    int m_grant;
    int m_pkts;
    int m_terr;
    int m_full;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_SRC; i++) sq[i].delete();
        expq.delete();
        m_owner = -1; m_rr = 0; m_starve = 0; m_grant = 0;
        m_pkts = 0; m_terr = 0; m_full = 0;
    endtask

    function automatic logic [15:0] body_header();
        logic [15:0] h;
        h = 16'($urandom());
        if (h == 16'hFFFF) h = 16'h0001;
        return h;
    endfunction

    task automatic push_packet(input int s, input int len);
        logic [31:0] r;
        for (int j = 0; j < len; j++) begin
            r = $urandom();
            sq[s].push_back({(j == len - 1) ? 16'hFFFF : body_header(), r});
        end
    endtask

    // One clock cycle: drive inputs, check registered outputs against the
    // model, predict this cycle's acceptance and advance the model.
    task automatic step(input int vpct, input int rpct);
        int          acc;
        int          exp_ready;
        int          s;
        logic        load;
        logic [47:0] f;
        logic [63:0] r;
        @(negedge clk);
        out_ready = ($urandom_range(0, 99) < rpct);
        for (int i = 0; i < NUM_SRC; i++) begin
            src_valid[i] = (sq[i].size() > 0) && ($urandom_range(0, 99) < vpct);
            r = {$urandom(), $urandom()};
            src_flit[48*i +: 48] = src_valid[i] ? sq[i][0] : r[47:0];
        end
        #1;
        chk("out_valid",   64'(out_valid),   64'(m_full));
        chk("busy",        64'(busy),        64'(m_owner >= 0));
        chk("grant_id",    64'(grant_id),    64'(m_grant));
        chk("timeout_err", 64'(timeout_err), 64'(m_terr));
        chk("pkt_count",   64'(pkt_count),   64'(m_pkts));

        load = !m_full || out_ready;
        acc = -1;
        exp_ready = 0;
        if (m_owner < 0) begin
            if (load) begin
                for (int k = 0; k < NUM_SRC; k++) begin
                    s = (m_rr + k) % NUM_SRC;
                    if (acc < 0 && src_valid[s]) acc = s;
                end
            end
            if (acc >= 0) exp_ready = 1 << acc;
        end else begin
            if (load) exp_ready = 1 << m_owner;
            if (load && src_valid[m_owner]) begin
                acc = m_owner;
            end else if (load) begin
                m_starve++;
                if (m_starve == TIMEOUT) begin
                    m_terr   = 1;
                    m_rr     = (m_owner + 1) % NUM_SRC;
                    m_owner  = -1;
                    m_starve = 0;
                end
            end
        end
        chk("src_ready", 64'(src_ready), 64'(exp_ready));

        if (acc >= 0) begin
            f = sq[acc].pop_front();
            expq.push_back(f);
            m_grant  = acc;
            m_starve = 0;
            m_full   = 1;
            if (f[47:32] == 16'hFFFF) begin
                m_pkts  = (m_pkts + 1) % 65536;
                m_rr    = (acc + 1) % NUM_SRC;
                m_owner = -1;
            end else begin
                m_owner = acc;
            end
        end else if (out_ready) begin
            m_full = 0;
        end
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear at once.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_out_valid",   64'(out_valid),   64'd0);
        chk("rst_out_flit",    64'(out_flit),    64'd0);
        chk("rst_busy",        64'(busy),        64'd0);
        chk("rst_grant_id",    64'(grant_id),    64'd0);
        chk("rst_timeout_err", 64'(timeout_err), 64'd0);
        chk("rst_pkt_count",   64'(pkt_count),   64'd0);
        model_clear();
        src_valid = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the output transfers.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset && out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL out_unexpected: got %0h expected no flit at %0t", out_flit, $time);
                end else begin
                    chk("out_flit", 64'(out_flit), 64'(expq.pop_front()));
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        src_flit  = '0;
        src_valid = '0;
        out_ready = 1'b0;
        model_clear();
        #12;
        chk("init_out_valid", 64'(out_valid),   64'd0);
        chk("init_out_flit",  64'(out_flit),    64'd0);
        chk("init_busy",      64'(busy),        64'd0);
        chk("init_grant_id",  64'(grant_id),    64'd0);
        chk("init_terr",      64'(timeout_err), 64'd0);
        chk("init_pkt_count", 64'(pkt_count),   64'd0);
        chk("init_src_ready", 64'(src_ready),   64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single source, three-flit packet.
        sq[0].push_back({16'h0001, 32'h1111_0000});
        sq[0].push_back({16'h0002, 32'h2222_0000});
        sq[0].push_back({16'hFFFF, 32'h3333_0000});
        repeat (3) step(100, 100);
        step(0, 100);
        chk("single_pkt_count", 64'(pkt_count), 64'd1);

        // Contention between src0 and src2 from reset.
        do_reset();
        push_packet(0, 2); push_packet(2, 2); push_packet(0, 2);
        repeat (8) step(100, 100);

        // Lock hold: src3 waits for src1's tail.
        push_packet(1, 3);
        step(100, 100);
        push_packet(3, 2);
        repeat (6) step(100, 100);

        // Backpressure mid-packet must not count as starvation.
        push_packet(2, 4);
        repeat (2) step(100, 100);
        repeat (10) step(100, 0);
        chk("bp_no_timeout", 64'(timeout_err), 64'd0);
        repeat (5) step(100, 100);

        // Watchdog: src0 stalls after one body flit; src1 is next.
        sq[0].push_back({16'h0001, 32'hDEAD_0000});
        push_packet(1, 1);
        repeat (8) step(100, 100);
        push_packet(0, 1);
        repeat (3) step(100, 100);
        chk("timeout_sticky", 64'(timeout_err), 64'd1);

        // Reset while locked with a held flit, then arbitrate from src0.
        push_packet(2, 5);
        repeat (2) step(100, 100);
        do_reset();
        push_packet(3, 1); push_packet(0, 1);
        repeat (4) step(100, 100);

        // Randomized traffic with varying source and downstream duty cycles.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NUM_SRC; i++)
                if (sq[i].size() == 0 && $urandom_range(0, 99) < 30)
                    push_packet(i, $urandom_range(1, 4));
            case (c / 500)
                0:       step(90, 50);
                1:       step(40, 90);
                2:       step(75, 75);
                default: step(100, 100);
            endcase
        end

        // pkt_count wrap after 65536 single-flit packets.
        step(0, 100);
        do_reset();
        for (int c = 0; c < 65536; c++) begin
            for (int i = 0; i < NUM_SRC; i++)
                if (sq[i].size() == 0) push_packet(i, 1);
            step(100, 100);
        end
        step(0, 100);
        chk("pkt_wrap", 64'(pkt_count), 64'd0);

        // Drain outstanding flits, bounded.
        for (int c = 0; c < 40 && (expq.size() > 0 || m_full != 0); c++)
            step(0, 100);
        #2;
        chk("drain_empty", 64'(expq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
